// File: rtl/alu_result_stage.sv
// ---------------------------------------------------------------------------
// alu_result_stage
//
// Registered output stage behind the 8-bit ALU. It accepts one result per
// cycle through a valid/ready handshake and holds up to two of them (a main
// entry and a skid entry). It presents the oldest entry to the writeback
// consumer. The stage also owns the architectural carry register, which
// feeds back to the ALU input_carry.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     ALU result valid
//   in_ready     stage can accept (registered, low only when FULL)
//   in_result    ALU result
//   in_flag      ALU flags {sign, zero, carry}
//   in_is_logic  producing op is a logic op (leaves carry untouched)
//   out_valid    head entry valid towards writeback
//   out_ready    writeback accepts the head entry
//   out_result   head result
//   out_flag     head flags
//   carry_clr    synchronous clear of the carry register
//   carry_q      architectural carry
//   perf_ops     (ALU_RESULT_PERF_EN only) saturating drain counter
//   perf_stall   (ALU_RESULT_PERF_EN only) saturating stall-cycle counter
//
// Build option: define ALU_RESULT_PERF_EN to add the two perf counters.
//
// state | meaning
// ------+-------------------------------------
// EMPTY | no entries held
// ONE   | main entry held
// FULL  | main and skid entries held
// ---------------------------------------------------------------------------
module alu_result_stage #(
    parameter int DATA_WIDTH = 8,
    parameter int FLAG_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic [FLAG_WIDTH-1:0] in_flag,
    input  logic                  in_is_logic,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [FLAG_WIDTH-1:0] out_flag,
    input  logic                  carry_clr,
`ifdef ALU_RESULT_PERF_EN
    output logic [15:0]           perf_ops,
    output logic [15:0]           perf_stall,
`endif
    output logic                  carry_q
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] main_result;
    logic [FLAG_WIDTH-1:0] main_flag;
    logic [DATA_WIDTH-1:0] skid_result;
    logic [FLAG_WIDTH-1:0] skid_flag;

    logic accept;
    logic drain;

    // Both handshakes use the registered ready/valid, so there is no
    // combinational path from out_ready to in_ready or from in_* to out_*.
    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    assign out_result = main_result;
    assign out_flag   = main_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            main_result <= '0;
            main_flag   <= '0;
            skid_result <= '0;
            skid_flag   <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_result <= in_result;
                        main_flag   <= in_flag;
                        state       <= ONE;
                        out_valid   <= 1'b1;
                        in_ready    <= 1'b1;
                    end
                end
                ONE: begin
                    if (accept && !drain) begin
                        skid_result <= in_result;
                        skid_flag   <= in_flag;
                        state       <= FULL;
                        in_ready    <= 1'b0;
                    end else if (drain && !accept) begin
                        state       <= EMPTY;
                        out_valid   <= 1'b0;
                    end else if (accept && drain) begin
                        // head leaves while the new result replaces it
                        main_result <= in_result;
                        main_flag   <= in_flag;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can happen
                    if (drain) begin
                        main_result <= skid_result;
                        main_flag   <= skid_flag;
                        state       <= ONE;
                        in_ready    <= 1'b1;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Carry follows accepted arithmetic ops immediately so back-to-back ops
    // chain without waiting for writeback; the clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (carry_clr) begin
            carry_q <= 1'b0;
        end else if (accept && !in_is_logic) begin
            carry_q <= in_flag[0];
        end
    end

`ifdef ALU_RESULT_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (drain && (perf_ops != 16'hFFFF)) begin
                perf_ops <= perf_ops + 16'd1;
            end
            if (out_valid && !out_ready && (perf_stall != 16'hFFFF)) begin
                perf_stall <= perf_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic [2:0] in_flag;
    logic       in_is_logic;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [2:0] out_flag;
    logic       carry_clr;
    logic       carry_q;
`ifdef ALU_RESULT_PERF_EN
    logic [15:0] perf_ops;
    logic [15:0] perf_stall;
`endif

    int total;
    int bad;

    alu_result_stage #(.DATA_WIDTH(8), .FLAG_WIDTH(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_flag     (in_flag),
        .in_is_logic (in_is_logic),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_flag    (out_flag),
        .carry_clr   (carry_clr),
`ifdef ALU_RESULT_PERF_EN
        .perf_ops    (perf_ops),
        .perf_stall  (perf_stall),
`endif
        .carry_q     (carry_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] res;
        logic [2:0] flg;
        logic       lg;
        logic       ordy;
        logic       clr;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_res;
        logic [2:0] e_flg;
        logic       e_c;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [7:0] r, input logic [2:0] f,
                         input logic lg, input logic ordy, input logic clr);
        in_valid    = iv;
        in_result   = r;
        in_flag     = f;
        in_is_logic = lg;
        out_ready   = ordy;
        carry_clr   = clr;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);

        //            iv  res    flg     lg  ordy clr  ir  ov  e_res  e_flg  c
        vecs[0]  = '{1'b1, 8'h5A, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 3'b001, 1'b1};
        vecs[1]  = '{1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 1'b1};
        vecs[2]  = '{1'b1, 8'h11, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 3'b000, 1'b1};
        vecs[3]  = '{1'b1, 8'h22, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'b000, 1'b1};
        vecs[4]  = '{1'b1, 8'h33, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 3'b000, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22, 3'b010, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 1'b1};
        vecs[7]  = '{1'b1, 8'h0F, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h0F, 3'b000, 1'b1};
        vecs[8]  = '{1'b1, 8'h80, 3'b100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h80, 3'b100, 1'b0};
        vecs[9]  = '{1'b1, 8'hFE, 3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFE, 3'b001, 1'b0};
        vecs[10] = '{1'b1, 8'h01, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE, 3'b001, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFE, 3'b001, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 3'b001, 1'b0};
        vecs[13] = '{1'b0, 8'h77, 3'b001, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'b000, 1'b0};

        #12;
        check("reset_in_ready",   32'(in_ready),   32'h1);
        check("reset_out_valid",  32'(out_valid),  32'h0);
        check("reset_out_result", 32'(out_result), 32'h0);
        check("reset_out_flag",   32'(out_flag),   32'h0);
        check("reset_carry",      32'(carry_q),    32'h0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].iv, vecs[i].res, vecs[i].flg, vecs[i].lg, vecs[i].ordy, vecs[i].clr);
            step();
            check($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ir));
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            check($sformatf("v%0d_carry", i),     32'(carry_q),   32'(vecs[i].e_c));
            if (vecs[i].e_ov) begin
                check($sformatf("v%0d_out_result", i), 32'(out_result), 32'(vecs[i].e_res));
                check($sformatf("v%0d_out_flag", i),   32'(out_flag),   32'(vecs[i].e_flg));
            end
        end

        // Asynchronous reset while FULL and stalled
        drive(1'b1, 8'hA1, 3'b001, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hA2, 3'b001, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'h0);
        check("full_carry",    32'(carry_q),  32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'h0);
        check("arst_carry",     32'(carry_q),   32'h0);
        check("arst_in_ready",  32'(in_ready),  32'h1);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 8'hFF, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        check("post_rst_valid",  32'(out_valid),  32'h1);
        check("post_rst_result", 32'(out_result), 32'hFF);
        drive(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        check("post_rst_alone_ready", 32'(in_ready),   32'h1);
        check("post_rst_hold",        32'(out_result), 32'hFF);
        out_ready = 1'b1;
        step();
        check("post_rst_empty", 32'(out_valid), 32'h0);
        out_ready = 1'b0;

`ifdef ALU_RESULT_PERF_EN
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        check("perf_reset_ops",   32'(perf_ops),   32'h0);
        check("perf_reset_stall", 32'(perf_stall), 32'h0);
        drive(1'b1, 8'hC1, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hC2, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 3'b000, 1'b0, 1'b0, 1'b0);
        step();
        step();
        step();
        check("perf_stall_4", 32'(perf_stall), 32'd4);
        drive(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'hC3, 3'b000, 1'b0, 1'b1, 1'b0);
        step();
        check("perf_c2_then_c3", 32'(out_result), 32'hC3);
        drive(1'b0, 8'h00, 3'b000, 1'b0, 1'b1, 1'b0);
        step();
        check("perf_ops_3",   32'(perf_ops),   32'd3);
        check("perf_stall_f", 32'(perf_stall), 32'd4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
